// File: rtl/ex_mem_reg_pkg.sv
// rtl/ex_mem_reg_pkg.sv - shared cpu types for the EX/MEM pipeline register
package ex_mem_reg_pkg;

  localparam int CPU_XLEN = 32;
  localparam int CPU_REGW = 5;

  // Register x0 is hard-wired to zero: never forwarded, never a hazard source.
  localparam logic [CPU_REGW-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FULL     = 2'd1,
    MEM_WAIT = 2'd2
  } ex_mem_state_e;

  typedef struct packed {
    logic                reg_write;
    logic                mem_read;
    logic                mem_write;
    logic                mem_to_reg;
    logic [CPU_REGW-1:0] rd;
    logic [CPU_XLEN-1:0] alu_result;
    logic [CPU_XLEN-1:0] store_data;
    logic [2:0]          funct3;
  } ex_mem_t;

  // Any instruction touching data memory must wait for the req/ack handshake.
  function automatic logic is_mem_op(input logic mem_read, input logic mem_write);
    return mem_read | mem_write;
  endfunction

endpackage

// File: rtl/ex_mem_reg.sv
// rtl/ex_mem_reg.sv - EX/MEM pipeline register with memory handshake and forwarding outputs
module ex_mem_reg
  import ex_mem_reg_pkg::*;
#(
  parameter int XLEN = CPU_XLEN,
  parameter int REGW = CPU_REGW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            exValid,
  output logic            exReady,
  input  logic            flush,
  input  logic            exRegWrite,
  input  logic            exMemRead,
  input  logic            exMemWrite,
  input  logic            exMemToReg,
  input  logic [REGW-1:0] exRd,
  input  logic [XLEN-1:0] exAluResult,
  input  logic [XLEN-1:0] exStoreData,
  input  logic [2:0]      exFunct3,
  input  logic [REGW-1:0] idRs,
  input  logic [REGW-1:0] idRt,
  output logic            memReq,
  input  logic            memAck,
  output logic [XLEN-1:0] memAddr,
  output logic [XLEN-1:0] memWData,
  output logic            memWe,
  output logic [2:0]      memFunct3,
  output logic            fwdRegWrite,
  output logic [REGW-1:0] fwdRd,
  output logic [XLEN-1:0] fwdData,
  output logic            loadHazard,
  output logic            wbValid
);

  // The held-instruction record uses the package widths; XLEN/REGW are
  // expected to stay equal to CPU_XLEN/CPU_REGW.

  ex_mem_state_e state_q, state_d;
  ex_mem_t       held_q, held_d;

  logic capture;
  logic held_is_load;
  logic held_rd_nonzero;
  logic unused_mem_to_reg;

  // Slot acceptance, capture decision and next-state selection.
  always_comb begin
    exReady = 1'b0;
    capture = 1'b0;
    state_d = state_q;
    held_d  = held_q;

    unique case (state_q)
      EMPTY:    exReady = 1'b1;
      FULL:     exReady = 1'b1;
      MEM_WAIT: exReady = memAck;
      default:  exReady = 1'b1;
    endcase

    capture = exValid & exReady & ~flush;

    if (exReady) begin
      if (capture) begin
        state_d           = is_mem_op(exMemRead, exMemWrite) ? MEM_WAIT : FULL;
        held_d.reg_write  = exRegWrite;
        held_d.mem_read   = exMemRead;
        held_d.mem_write  = exMemWrite;
        held_d.mem_to_reg = exMemToReg;
        held_d.rd         = exRd;
        held_d.alu_result = exAluResult;
        held_d.store_data = exStoreData;
        held_d.funct3     = exFunct3;
      end else begin
        // Retiring with nothing behind it leaves a bubble; data is kept
        // but is never forwarded because the state gates it.
        state_d = EMPTY;
      end
    end
  end

  // State and held-instruction registers; reset empties the slot at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      held_q  <= '0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
    end
  end

  // Both load and store set is treated as a store, so it is not a load here.
  assign held_is_load    = held_q.mem_read & ~held_q.mem_write;
  assign held_rd_nonzero = (held_q.rd != REG_ZERO);

  assign memReq    = (state_q == MEM_WAIT);
  assign memAddr   = held_q.alu_result;
  assign memWData  = held_q.store_data;
  assign memWe     = held_q.mem_write;
  assign memFunct3 = held_q.funct3;

  assign fwdRegWrite = (state_q != EMPTY) & held_q.reg_write & held_rd_nonzero;
  assign fwdRd       = held_q.rd;
  assign fwdData     = held_q.alu_result;

  assign wbValid = (state_q == FULL) | ((state_q == MEM_WAIT) & memAck);

  // A load result is not available for forwarding here, so a dependent
  // instruction in ID must stall; EX is also frozen while the access waits.
  assign loadHazard = ((state_q != EMPTY) & held_is_load & held_rd_nonzero &
                       ((held_q.rd == idRs) | (held_q.rd == idRt))) |
                      ((state_q == MEM_WAIT) & ~memAck);

  // mem_to_reg travels with the instruction for the MEM/WB stage.
  assign unused_mem_to_reg = held_q.mem_to_reg;

endmodule

// File: tb/tb_ex_mem_reg.sv
// tb/tb_ex_mem_reg.sv - scoreboard testbench for ex_mem_reg
module tb_ex_mem_reg;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        exValid = 1'b0, flush = 1'b0;
  logic        exRegWrite = 1'b0, exMemRead = 1'b0, exMemWrite = 1'b0, exMemToReg = 1'b0;
  logic [4:0]  exRd = '0, idRs = '0, idRt = '0;
  logic [31:0] exAluResult = '0, exStoreData = '0;
  logic [2:0]  exFunct3 = '0;
  logic        memAck = 1'b0;
  logic        exReady, memReq, memWe, fwdRegWrite, loadHazard, wbValid;
  logic [31:0] memAddr, memWData, fwdData;
  logic [2:0]  memFunct3;
  logic [4:0]  fwdRd;

  ex_mem_reg dut (
    .clk(clk), .rst_n(rst_n), .exValid(exValid), .exReady(exReady), .flush(flush),
    .exRegWrite(exRegWrite), .exMemRead(exMemRead), .exMemWrite(exMemWrite),
    .exMemToReg(exMemToReg), .exRd(exRd), .exAluResult(exAluResult),
    .exStoreData(exStoreData), .exFunct3(exFunct3), .idRs(idRs), .idRt(idRt),
    .memReq(memReq), .memAck(memAck), .memAddr(memAddr), .memWData(memWData),
    .memWe(memWe), .memFunct3(memFunct3), .fwdRegWrite(fwdRegWrite), .fwdRd(fwdRd),
    .fwdData(fwdData), .loadHazard(loadHazard), .wbValid(wbValid)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        v, fl, rw, mr, mw, m2r;
    bit [4:0]  rd, rs, rt;
    bit [31:0] alu, sd;
    bit [2:0]  f3;
    bit        ack;
  } stim_t;

  typedef struct {
    bit        rw, mr, mw;
    bit [4:0]  rd;
    bit [31:0] alu, sd;
    bit [2:0]  f3;
  } ins_t;

  typedef struct {
    bit        ready, req, wb, frw, haz, has;
    bit [4:0]  rd;
    bit [31:0] data, addr, wdata;
    bit        we;
    bit [2:0]  f3;
  } exp_t;

  ins_t slot[$];
  ins_t ret_q[$];
  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic stim_t idle(input bit ack);
    stim_t s = '{default: '0};
    s.ack = ack;
    return s;
  endfunction

  function automatic stim_t op(input int kind, input bit [4:0] rd, input bit [31:0] alu,
                               input bit [31:0] sd, input bit [4:0] rs, input bit ack);
    stim_t s = '{default: '0};
    s.v   = 1'b1;
    s.rw  = (kind != 2);
    s.mr  = (kind == 1);
    s.mw  = (kind == 2);
    s.m2r = (kind == 1);
    s.rd  = rd;
    s.alu = alu;
    s.sd  = sd;
    s.f3  = 3'd2;
    s.rs  = rs;
    s.rt  = 5'd31;
    s.ack = ack;
    return s;
  endfunction

  // Drive one cycle: compute what the slot should show, queue it for the
  // monitor, then advance the reference slot across the clock edge.
  task automatic step(input stim_t s);
    exp_t e;
    ins_t cur;
    bit   is_mem;
    exValid = s.v; flush = s.fl; exRegWrite = s.rw; exMemRead = s.mr;
    exMemWrite = s.mw; exMemToReg = s.m2r; exRd = s.rd; exAluResult = s.alu;
    exStoreData = s.sd; exFunct3 = s.f3; idRs = s.rs; idRt = s.rt; memAck = s.ack;

    e = '{default: '0};
    e.has  = (slot.size() != 0);
    cur    = e.has ? slot[0] : '{default: '0};
    is_mem = e.has && (cur.mr || cur.mw);
    e.ready = !e.has || !is_mem || s.ack;
    e.req   = is_mem;
    e.wb    = e.has && (!is_mem || s.ack);
    e.frw   = e.has && cur.rw && (cur.rd != 0);
    e.haz   = (e.has && cur.mr && !cur.mw && cur.rd != 0 && (cur.rd == s.rs || cur.rd == s.rt))
              || (is_mem && !s.ack);
    e.rd = cur.rd; e.data = cur.alu; e.addr = cur.alu; e.wdata = cur.sd;
    e.we = cur.mw; e.f3 = cur.f3;
    exp_q.push_back(e);

    if (e.ready) begin
      slot.delete();
      if (s.v && !s.fl) begin
        ins_t n;
        n.rw = s.rw; n.mr = s.mr; n.mw = s.mw; n.rd = s.rd;
        n.alu = s.alu; n.sd = s.sd; n.f3 = s.f3;
        slot.push_back(n);
        ret_q.push_back(n);
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every presented cycle against the queued expectation,
  // and every retirement against the capture order.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("exReady", 32'(exReady), 32'(e.ready));
        chk("memReq", 32'(memReq), 32'(e.req));
        chk("wbValid", 32'(wbValid), 32'(e.wb));
        chk("fwdRegWrite", 32'(fwdRegWrite), 32'(e.frw));
        chk("loadHazard", 32'(loadHazard), 32'(e.haz));
        if (e.has) begin
          chk("fwdRd", 32'(fwdRd), 32'(e.rd));
          chk("fwdData", fwdData, e.data);
        end
        if (e.req) begin
          chk("memAddr", memAddr, e.addr);
          chk("memWData", memWData, e.wdata);
          chk("memWe", 32'(memWe), 32'(e.we));
          chk("memFunct3", 32'(memFunct3), 32'(e.f3));
        end
      end
      if (wbValid === 1'b1) begin
        if (ret_q.size() == 0) begin
          chk("retire_unexpected", 32'(wbValid), 32'd0);
        end else begin
          ins_t r;
          r = ret_q.pop_front();
          chk("retire_rd", 32'(fwdRd), 32'(r.rd));
          chk("retire_data", fwdData, r.alu);
        end
      end
    end
  end

  initial begin
    stim_t s;
    // Reset values while rst_n is held low.
    #1;
    chk("rst_exReady", 32'(exReady), 32'd1);
    chk("rst_memReq", 32'(memReq), 32'd0);
    chk("rst_fwdRegWrite", 32'(fwdRegWrite), 32'd0);
    chk("rst_loadHazard", 32'(loadHazard), 32'd0);
    chk("rst_wbValid", 32'(wbValid), 32'd0);
    chk("rst_fwdData", fwdData, 32'd0);
    #11 rst_n = 1'b1;
    @(posedge clk); #1;

    // ALU op rd=5 result 0x1234, then bubbles.
    step(op(0, 5'd5, 32'h1234, 32'h0, 5'd0, 1'b0));
    step(idle(1'b0));
    step(idle(1'b0));

    // Load rd=7 with idRs=7, ack on the third MEM_WAIT cycle.
    step(op(1, 5'd7, 32'h40, 32'h0, 5'd7, 1'b0));
    s = idle(1'b0); s.rs = 5'd7;
    step(s); step(s);
    s.ack = 1'b1;
    step(s);
    step(idle(1'b0));

    // Store, with a flushed op offered on the ack cycle.
    step(op(2, 5'd0, 32'h100, 32'hDEADBEEF, 5'd0, 1'b0));
    step(idle(1'b0));
    s = op(0, 5'd9, 32'h55, 32'h0, 5'd0, 1'b1); s.fl = 1'b1;
    step(s);
    step(idle(1'b0));

    // Two loads back-to-back, each acked on its first MEM_WAIT cycle.
    step(op(1, 5'd3, 32'h200, 32'h0, 5'd0, 1'b0));
    step(op(1, 5'd4, 32'h204, 32'h0, 5'd0, 1'b1));
    step(idle(1'b1));
    step(idle(1'b0));

    // Load to x0 with idRs=0: access issued, no forward, no hazard.
    step(op(1, 5'd0, 32'h300, 32'h0, 5'd0, 1'b0));
    step(idle(1'b1));
    step(idle(1'b0));

    // Randomised traffic with sparse register indices to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      s = op(int'($urandom_range(0, 2)), 5'($urandom_range(0, 7)), $urandom, $urandom,
             5'($urandom_range(0, 7)), ($urandom_range(0, 9) < 4));
      s.v  = ($urandom_range(0, 3) != 0);
      s.fl = ($urandom_range(0, 7) == 0);
      s.rt = 5'($urandom_range(0, 7));
      s.f3 = 3'($urandom_range(0, 7));
      s.rw = s.rw & ($urandom_range(0, 4) != 0);
      step(s);
    end
    for (int i = 0; i < 4; i++) step(idle(1'b1));

    // Reset asserted mid-access must drop the request before the next edge.
    step(op(1, 5'd6, 32'h400, 32'h0, 5'd0, 1'b0));
    step(idle(1'b0));
    @(negedge clk);
    chk("pre_rst_memReq", 32'(memReq), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_memReq", 32'(memReq), 32'd0);
    chk("midrst_exReady", 32'(exReady), 32'd1);
    chk("midrst_fwdRegWrite", 32'(fwdRegWrite), 32'd0);
    chk("midrst_fwdRd", 32'(fwdRd), 32'd0);
    chk("midrst_fwdData", fwdData, 32'd0);
    slot.delete();
    ret_q.delete();
    @(posedge clk); #2;
    rst_n = 1'b1;
    #1;

    // Slot is usable again after reset.
    step(op(0, 5'd12, 32'hCAFE, 32'h0, 5'd0, 1'b0));
    step(idle(1'b0));
    step(idle(1'b0));
    @(negedge clk); #1;
    chk("retire_queue_drained", 32'(ret_q.size()), 32'd0);
    chk("expect_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
